// File: rtl/dmem_access_master_pkg.sv
// Shared definitions for the data-memory access master: access-size encodings,
// FSM state type, request payload and the default data-memory window.
package dmem_access_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Default data-memory window, also used by dmemory models and benches.
    localparam logic [ADDR_W-1:0] BASE_ADDR = 32'h0100_0000;
    localparam int unsigned       MEM_BYTES = 1048576;

    // Access-size encodings (funct3[1:0] and mem_access_size).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Latched load/store request.
    typedef struct packed {
        logic              store;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Natural alignment of an access from its two low address bits.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~addr_lo[0];
            default: is_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_master_load_extend.sv
// Combinational size/sign extension of LSB-aligned load data.
// Ports:
//   raw_data    - assembled load bytes, LSB-aligned
//   size        - 0=byte, 1=half, 2=word
//   is_unsigned - 1 selects zero extension
//   ext_data_c  - extended 32-bit result (combinational)
module dmem_access_master_load_extend
    import dmem_access_master_pkg::*;
(
    input  logic [DATA_W-1:0] raw_data,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] ext_data_c
);

    logic sign_byte;
    logic sign_half;

    assign sign_byte = raw_data[7]  & ~is_unsigned;
    assign sign_half = raw_data[15] & ~is_unsigned;

    // Replicate the selected sign bit above the accessed width.
    always_comb begin
        ext_data_c = raw_data;
        case (size)
            SZ_BYTE: ext_data_c = {{24{sign_byte}}, raw_data[7:0]};
            SZ_HALF: ext_data_c = {{16{sign_half}}, raw_data[15:0]};
            default: ext_data_c = raw_data;
        endcase
    end

endmodule

// File: rtl/dmem_access_master.sv
// Initiator side of the dmemory port. Accepts one load/store per handshake,
// range-checks it, issues one beat (aligned) or byte beats (misaligned half/word),
// reassembles and extends load data, and returns a held response.
// Ports:
//   clock, reset_n                       - clock, synchronous active-low reset
//   req_valid/req_ready                  - request handshake (ready only in IDLE)
//   req_store, req_funct3, req_addr, req_wdata - request payload
//   rsp_valid/rsp_ready                  - response handshake, response held until taken
//   rsp_rdata, rsp_err                   - extended load data, range/size error
//   mem_address, mem_read_write, mem_access_size, mem_load_un, mem_data_in - beat to dmemory
//   mem_data_out                         - dmemory read data, valid the cycle after the address
module dmem_access_master #(
    parameter logic [31:0] BASE_ADDR = dmem_access_master_pkg::BASE_ADDR,
    parameter int unsigned MEM_BYTES = dmem_access_master_pkg::MEM_BYTES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_load_un,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    import dmem_access_master_pkg::*;

    // End of the legal window, kept in 33 bits so address wrap is caught.
    localparam logic [32:0] MEM_END = 33'(BASE_ADDR) + 33'(MEM_BYTES);

    state_e            state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic              split_q, split_d;
    logic [1:0]        beat_q, beat_d;
    logic [DATA_W-1:0] asm_q, asm_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_write_q, mem_read_write_d;
    logic [1:0]        mem_access_size_q, mem_access_size_d;
    logic              mem_load_un_q, mem_load_un_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;

    logic              illegal_size_c;
    logic              range_err_c;
    logic [32:0]       acc_end_c;
    logic              last_beat_c;
    logic [DATA_W-1:0] asm_merge_c;
    logic [DATA_W-1:0] ext_data_c;

    // Request classification on the live request inputs.
    always_comb begin
        illegal_size_c = (req_funct3[1:0] == 2'd3);
        acc_end_c      = {1'b0, req_addr} + 33'(size_bytes(req_funct3[1:0]));
        range_err_c    = (req_addr < BASE_ADDR) || (acc_end_c > MEM_END);
    end

    // Current beat is the final one of the latched request.
    assign last_beat_c = ~split_q ||
                         (beat_q == 2'(size_bytes(req_q.funct3[1:0]) - 3'd1));

    // Returned byte merged into its lane of the assembly register.
    always_comb begin
        asm_merge_c = asm_q;
        asm_merge_c[{beat_q, 3'b000} +: 8] = mem_data_out[7:0];
    end

    dmem_access_master_load_extend u_load_extend (
        .raw_data    (asm_merge_c),
        .size        (req_q.funct3[1:0]),
        .is_unsigned (req_q.funct3[2]),
        .ext_data_c  (ext_data_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d           = state_q;
        req_d             = req_q;
        split_d           = split_q;
        beat_d            = beat_q;
        asm_d             = asm_q;
        rsp_rdata_d       = rsp_rdata_q;
        rsp_err_d         = rsp_err_q;
        mem_address_d     = mem_address_q;
        mem_access_size_d = mem_access_size_q;
        mem_load_un_d     = mem_load_un_q;
        mem_data_in_d     = mem_data_in_q;
        mem_read_write_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.store  = req_store;
                    req_d.funct3 = req_funct3;
                    req_d.addr   = req_addr;
                    req_d.wdata  = req_wdata;
                    split_d      = ~is_aligned(req_funct3[1:0], req_addr[1:0]);
                    beat_d       = 2'd0;
                    asm_d        = '0;
                    rsp_rdata_d  = '0;
                    if (illegal_size_c || range_err_c) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!req_q.store) begin
                    state_d = CAPTURE;
                end else if (last_beat_c) begin
                    state_d = RESP;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            CAPTURE: begin
                if (!split_q) begin
                    // dmemory already extended a single-beat load.
                    rsp_rdata_d = mem_data_out;
                    state_d     = RESP;
                end else begin
                    asm_d = asm_merge_c;
                    if (last_beat_c) begin
                        rsp_rdata_d = ext_data_c;
                        state_d     = RESP;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = ACCESS;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);

        // Beat to be presented while in ACCESS after this edge.
        if (state_d == ACCESS) begin
            mem_read_write_d = req_d.store;
            if (split_d) begin
                mem_address_d     = req_d.addr + 32'(beat_d);
                mem_access_size_d = SZ_BYTE;
                mem_load_un_d     = 1'b1;
                mem_data_in_d     = {24'h0, req_d.wdata[{beat_d, 3'b000} +: 8]};
            end else begin
                mem_address_d     = req_d.addr;
                mem_access_size_d = req_d.funct3[1:0];
                mem_load_un_d     = req_d.funct3[2];
                mem_data_in_d     = req_d.wdata;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            req_q             <= '0;
            split_q           <= 1'b0;
            beat_q            <= 2'd0;
            asm_q             <= '0;
            req_ready_q       <= 1'b1;
            rsp_valid_q       <= 1'b0;
            rsp_rdata_q       <= '0;
            rsp_err_q         <= 1'b0;
            mem_address_q     <= BASE_ADDR;
            mem_read_write_q  <= 1'b0;
            mem_access_size_q <= SZ_WORD;
            mem_load_un_q     <= 1'b0;
            mem_data_in_q     <= '0;
        end else begin
            state_q           <= state_d;
            req_q             <= req_d;
            split_q           <= split_d;
            beat_q            <= beat_d;
            asm_q             <= asm_d;
            req_ready_q       <= req_ready_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_rdata_q       <= rsp_rdata_d;
            rsp_err_q         <= rsp_err_d;
            mem_address_q     <= mem_address_d;
            mem_read_write_q  <= mem_read_write_d;
            mem_access_size_q <= mem_access_size_d;
            mem_load_un_q     <= mem_load_un_d;
            mem_data_in_q     <= mem_data_in_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign mem_address     = mem_address_q;
    assign mem_read_write  = mem_read_write_q;
    assign mem_access_size = mem_access_size_q;
    assign mem_load_un     = mem_load_un_q;
    assign mem_data_in     = mem_data_in_q;

endmodule

// File: tb/tb_dmem_access_master.sv
// Directed bench for dmem_access_master with a byte-array dmemory model and a
// byte-level reference model of the expected responses and write beats.
module tb_dmem_access_master;
    import dmem_access_master_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic        mem_load_un;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = 32'h0;

    always #5 clock = ~clock;

    dmem_access_master dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_address     (mem_address),
        .mem_read_write  (mem_read_write),
        .mem_access_size (mem_access_size),
        .mem_load_un     (mem_load_un),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  s;
        logic [31:0] d;
    } beat_t;

    beat_t      exp_wr[$];
    logic [7:0] dm      [0:65535];
    logic [7:0] ref_mem [0:65535];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Keep the low nb bytes of v and extend them to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] v, input int nb, input bit un);
        logic [31:0] mask;
        bit          neg;
        if (nb >= 4) return v;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        neg  = !un && v[8 * nb - 1];
        return (v & mask) | (neg ? ~mask : 32'h0);
    endfunction

    function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [1:0] s, input bit un);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(s); i++) v[8 * i +: 8] = dm[16'(a + 32'(i))];
        return extend(v, nbytes(s), un);
    endfunction

    // dmemory: writes at the clock edge, read data registered one cycle after the address.
    always @(posedge clock) begin
        if (mem_read_write) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(mem_access_size))
                    dm[16'(mem_address + 32'(i))] <= mem_data_in[8 * i +: 8];
        end
        mem_data_out <= dm_read(mem_address, mem_access_size, mem_load_un);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and check the write beat and handshake exclusion.
    task automatic tick();
        beat_t e;
        @(negedge clock);
        if (mem_read_write) begin
            n_tests++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL write beat: unexpected write addr %h data %h", mem_address, mem_data_in);
            end else begin
                e = exp_wr.pop_front();
                if ({mem_address, mem_access_size, mem_data_in} !== e) begin
                    n_fail++;
                    $display("FAIL write beat: got a=%h s=%0d d=%h, want a=%h s=%0d d=%h",
                             mem_address, mem_access_size, mem_data_in, e.a, e.s, e.d);
                end
            end
        end
        if (rsp_valid && req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready/valid overlap: req_ready=1 while rsp_valid=1");
        end
    endtask

    // Reference model: error, latency, load data and expected write beats from the byte rules.
    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit err, output int lat,
                         output logic [31:0] rd);
        longint unsigned lo = longint'(a);
        int              nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        int              beats;
        logic [31:0]     v = 32'h0;
        beat_t           b;
        err   = (f3[1:0] == 2'd3) || (lo < longint'(BASE_ADDR)) ||
                (lo + longint'(nb) > longint'(BASE_ADDR) + longint'(MEM_BYTES));
        beats = ((a % nb) == 0) ? 1 : nb;
        rd    = 32'h0;
        if (err) begin
            lat = 1;
        end else if (st) begin
            lat = beats + 1;
            if (beats == 1) begin
                b.a = a; b.s = f3[1:0]; b.d = wd;
                exp_wr.push_back(b);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    b.a = a + 32'(k); b.s = 2'd0; b.d = {24'h0, wd[8 * k +: 8]};
                    exp_wr.push_back(b);
                end
            end
            for (int k = 0; k < nb; k++) ref_mem[16'(a + 32'(k))] = wd[8 * k +: 8];
        end else begin
            lat = 2 * beats + 1;
            for (int k = 0; k < nb; k++) v[8 * k +: 8] = ref_mem[16'(a + 32'(k))];
            rd = extend(v, nb, f3[2]);
        end
    endtask

    task automatic start_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input bit keep, output int waits);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (waits >= 20) check_int("req_ready timeout", waits, 0);
        @(posedge clock);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic run_req(input string name, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           input bit keep, output logic [31:0] rd, output int lat,
                           output int waits);
        bit          e_err;
        int          e_lat;
        logic [31:0] e_rd;
        logic        err0;
        model(st, f3, a, wd, e_err, e_lat, e_rd);
        start_req(st, f3, a, wd, keep, waits);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) lat = -1;
        check_int({name, " latency"}, lat, e_lat);
        check32({name, " rdata"}, rsp_rdata, e_rd);
        check32({name, " err"}, 32'(rsp_err), 32'(e_err));
        rd   = rsp_rdata;
        err0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            check32({name, " held valid/err/ready"}, {29'h0, rsp_valid, rsp_err, req_ready},
                    {29'h0, 1'b1, err0, 1'b0});
            check32({name, " held rdata"}, rsp_rdata, rd);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        tick();
        check32({name, " after handshake ready/valid"}, {30'h0, req_ready, rsp_valid}, 32'h2);
        check_int({name, " beats outstanding"}, exp_wr.size(), 0);
    endtask

    task automatic check_reset(input string name);
        check32({name, " req_ready"},       32'(req_ready),       32'h1);
        check32({name, " rsp_valid"},       32'(rsp_valid),       32'h0);
        check32({name, " rsp_rdata"},       rsp_rdata,            32'h0);
        check32({name, " rsp_err"},         32'(rsp_err),         32'h0);
        check32({name, " mem_address"},     mem_address,          BASE_ADDR);
        check32({name, " mem_read_write"},  32'(mem_read_write),  32'h0);
        check32({name, " mem_access_size"}, 32'(mem_access_size), 32'h2);
        check32({name, " mem_load_un"},     32'(mem_load_un),     32'h0);
        check32({name, " mem_data_in"},     mem_data_in,          32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          w;
        beat_t       b;

        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        reset_n = 1'b1;
        tick();

        // Aligned word store and load-back.
        run_req("sw aligned", 1'b1, 3'd2, BASE_ADDR, 32'h0000_55D4, 0, 1'b0, rd, lat, w);
        check_int("sw aligned latency literal", lat, 2);
        run_req("lw aligned", 1'b0, 3'd2, BASE_ADDR, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lw aligned literal", rd, 32'h0000_55D4);
        check_int("lw aligned latency literal", lat, 3);

        // Byte/half loads with sign and zero extension.
        run_req("sw pattern", 1'b1, 3'd2, BASE_ADDR, 32'h80FF_7F01, 0, 1'b0, rd, lat, w);
        run_req("lb +1", 1'b0, 3'd0, BASE_ADDR + 32'd1, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lb +1 literal", rd, 32'h0000_007F);
        run_req("lb +2", 1'b0, 3'd0, BASE_ADDR + 32'd2, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lb +2 literal", rd, 32'hFFFF_FFFF);
        run_req("lbu +3", 1'b0, 3'd4, BASE_ADDR + 32'd3, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lbu +3 literal", rd, 32'h0000_0080);
        run_req("lh +2", 1'b0, 3'd1, BASE_ADDR + 32'd2, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lh +2 literal", rd, 32'hFFFF_80FF);

        // Misaligned accesses split into byte beats.
        run_req("sw misaligned", 1'b1, 3'd2, BASE_ADDR + 32'd1, 32'hA1B2_C3D4, 0, 1'b0, rd, lat, w);
        check_int("sw misaligned latency literal", lat, 5);
        run_req("lw misaligned", 1'b0, 3'd2, BASE_ADDR + 32'd1, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lw misaligned literal", rd, 32'hA1B2_C3D4);
        check_int("lw misaligned latency literal", lat, 9);
        run_req("sh misaligned", 1'b1, 3'd1, BASE_ADDR + 32'h11, 32'h0000_BEEF, 0, 1'b0, rd, lat, w);
        check_int("sh misaligned latency literal", lat, 3);
        run_req("lhu misaligned", 1'b0, 3'd5, BASE_ADDR + 32'h11, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lhu misaligned literal", rd, 32'h0000_BEEF);
        run_req("lh misaligned", 1'b0, 3'd1, BASE_ADDR + 32'h11, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lh misaligned literal", rd, 32'hFFFF_BEEF);

        // Range and size errors, including address wrap, and the last legal word.
        run_req("lw below base", 1'b0, 3'd2, 32'h00FF_FFFC, 32'h0, 0, 1'b0, rd, lat, w);
        check_int("lw below base latency literal", lat, 1);
        check32("lw below base err literal", 32'(rsp_err), 32'h1);
        run_req("sw past end", 1'b1, 3'd2, BASE_ADDR + 32'(MEM_BYTES) - 32'd2, 32'hDEAD_BEEF,
                0, 1'b0, rd, lat, w);
        check32("sw past end rdata literal", rd, 32'h0);
        run_req("illegal size", 1'b0, 3'd3, BASE_ADDR, 32'h0, 0, 1'b0, rd, lat, w);
        run_req("lw wrap", 1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 0, 1'b0, rd, lat, w);
        run_req("sw last word", 1'b1, 3'd2, BASE_ADDR + 32'(MEM_BYTES) - 32'd4, 32'h1234_5678,
                0, 1'b0, rd, lat, w);
        run_req("lw last word", 1'b0, 3'd2, BASE_ADDR + 32'(MEM_BYTES) - 32'd4, 32'h0,
                0, 1'b0, rd, lat, w);
        check32("lw last word literal", rd, 32'h1234_5678);

        // Response held with req_valid high; re-accept one cycle after the handshake.
        run_req("sw hold", 1'b1, 3'd2, BASE_ADDR + 32'h20, 32'hCAFE_F00D, 5, 1'b1, rd, lat, w);
        run_req("sw reaccept", 1'b1, 3'd2, BASE_ADDR + 32'h20, 32'hCAFE_F00D, 0, 1'b0, rd, lat, w);
        check_int("reaccept wait cycles", w, 0);

        // Reset during the second beat of a misaligned store.
        run_req("sw zero lo", 1'b1, 3'd2, BASE_ADDR + 32'h100, 32'h0, 0, 1'b0, rd, lat, w);
        run_req("sw zero hi", 1'b1, 3'd2, BASE_ADDR + 32'h104, 32'h0, 0, 1'b0, rd, lat, w);
        b.a = BASE_ADDR + 32'h101; b.s = 2'd0; b.d = 32'h44; exp_wr.push_back(b);
        b.a = BASE_ADDR + 32'h102; b.s = 2'd0; b.d = 32'h33; exp_wr.push_back(b);
        ref_mem[16'(BASE_ADDR + 32'h101)] = 8'h44;
        ref_mem[16'(BASE_ADDR + 32'h102)] = 8'h33;
        start_req(1'b1, 3'd2, BASE_ADDR + 32'h101, 32'h1122_3344, 1'b0, w);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        check_reset("mid-op reset");
        check_int("mid-op reset beats issued", exp_wr.size(), 0);
        reset_n = 1'b1;
        tick();
        run_req("lw after reset lo", 1'b0, 3'd2, BASE_ADDR + 32'h100, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lw after reset lo literal", rd, 32'h0033_4400);
        run_req("lw after reset hi", 1'b0, 3'd2, BASE_ADDR + 32'h104, 32'h0, 0, 1'b0, rd, lat, w);
        check32("lw after reset hi literal", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
